sample_clock_gen: RTL and testbench

Programmable sample-rate generator for the audio subsystem. It replaces the fixed power-of-two divider with a fractional (phase-accumulator) divider that runs off the system clock. It produces N independent channel strobes, each with its own run-time increment. Each channel emits a one-cycle tick plus a 50%-ish square clock, for use by synth voices, the PDM/PWM output stage and the sample FIFOs.

---
 rtl/sample_clock_gen.sv | 71 +++++++
 tb/tb_sample_clock_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sample_clock_gen.sv
// sample_clock_gen: N-channel fractional phase-accumulator sample-rate generator.
// Optional LFSR dither on the accumulator LSB when SAMPLE_CLOCK_DITHER_EN is defined.
module sample_clock_gen #(
    parameter int          NCHAN   = 2,
    parameter int          ACC_W   = 24,
    parameter logic [31:0] DEF_INC = 32'h000400
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      inc_wr,
    input  logic [(NCHAN > 1 ? $clog2(NCHAN) : 1)-1:0] inc_sel,
    input  logic [ACC_W-1:0]                          inc_data,
    input  logic                                      en_wr,
    input  logic                                      en_data,
    input  logic                                      sync,
    output logic [NCHAN-1:0]                          sample_tick,
    output logic [NCHAN-1:0]                          sample_clock,
    output logic [NCHAN*ACC_W-1:0]                    phase
);
    localparam int SW = NCHAN > 1 ? $clog2(NCHAN) : 1;
    logic [NCHAN-1:0][ACC_W-1:0] acc;
    logic [NCHAN-1:0][ACC_W-1:0] inc;
    logic [NCHAN-1:0][ACC_W:0]   sum;
    logic [NCHAN-1:0]            en;
    logic [NCHAN-1:0]            dith;
    assign phase = acc;
`ifdef SAMPLE_CLOCK_DITHER_EN
    logic [15:0] lfsr;
    // Galois LFSR, taps 16,14,13,11, shifting right
    always_ff @(posedge clk)
        lfsr <= rst ? 16'hACE1 : {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    always_comb
        for (int k = 0; k < NCHAN; k++)
            dith[k] = lfsr[k % 16];
`else
    assign dith = '0;
`endif
    always_comb
        for (int k = 0; k < NCHAN; k++)
            sum[k] = {1'b0, acc[k]} + {1'b0, inc[k]} + {{ACC_W{1'b0}}, dith[k]};
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCHAN; k++) begin
                acc[k] <= '0;
                inc[k] <= DEF_INC[ACC_W-1:0];
            end
            en           <= '1;
            sample_tick  <= '0;
            sample_clock <= '0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                if (sync) begin
                    acc[k]          <= '0;
                    sample_tick[k]  <= 1'b0;
                    sample_clock[k] <= 1'b0;
                end else if (en[k]) begin
                    acc[k]          <= sum[k][ACC_W-1:0];
                    sample_tick[k]  <= sum[k][ACC_W];
                    sample_clock[k] <= sum[k][ACC_W-1];
                end else begin
                    sample_tick[k]  <= 1'b0;
                end
                // out-of-range selects match no channel, so such writes drop
                if (inc_wr && inc_sel == SW'(k))
                    inc[k] <= inc_data;
                if (en_wr && inc_sel == SW'(k))
                    en[k] <= en_data;
            end
        end
    end
endmodule

// File: tb/tb_sample_clock_gen.sv
// tb_sample_clock_gen: directed checks of sample_clock_gen (24-bit/2-ch and 8-bit/3-ch builds).
module tb_sample_clock_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_inc_wr = 1'b0, a_en_wr = 1'b0, a_en_data = 1'b0, a_sync = 1'b0;
    logic        a_sel = 1'b0;
    logic [23:0] a_inc_data = '0;
    logic [1:0]  a_tick, a_clock;
    logic [47:0] a_phase;
    logic        b_inc_wr = 1'b0, b_en_wr = 1'b0, b_en_data = 1'b0, b_sync = 1'b0;
    logic [1:0]  b_sel = '0;
    logic [7:0]  b_inc_data = '0;
    logic [2:0]  b_tick, b_clock;
    logic [23:0] b_phase;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sample_clock_gen #(.NCHAN(2), .ACC_W(24)) dut_a (
        .clk(clk), .rst(rst), .inc_wr(a_inc_wr), .inc_sel(a_sel), .inc_data(a_inc_data),
        .en_wr(a_en_wr), .en_data(a_en_data), .sync(a_sync),
        .sample_tick(a_tick), .sample_clock(a_clock), .phase(a_phase));

    sample_clock_gen #(.NCHAN(3), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst), .inc_wr(b_inc_wr), .inc_sel(b_sel), .inc_data(b_inc_data),
        .en_wr(b_en_wr), .en_data(b_en_data), .sync(b_sync),
        .sample_tick(b_tick), .sample_clock(b_clock), .phase(b_phase));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first, hi, cnt, bcnt, last, mn, mx, win, t0, t1;
        repeat (3) step();
        check("rst_phase_a", 64'(a_phase), 64'h0);
        check("rst_tick_a", 64'(a_tick), 64'h0);
        check("rst_clock_a", 64'(a_clock), 64'h0);
        check("rst_phase_b", 64'(b_phase), 64'h0);
        rst = 1'b0;
        first = 0; hi = 0; cnt = 0; bcnt = 0;
        for (int n = 1; n <= 16384; n++) begin
            step();
            if (a_tick[0]) begin
                cnt++;
                if (first == 0) first = n;
            end
            hi += int'(a_clock[0]);
            bcnt += int'(b_tick != 3'b000);
        end
        check("first_tick", 64'(first), 64'd16384);
        check("clock_high", 64'(hi), 64'd8192);
        check("tick_count", 64'(cnt), 64'd1);
        check("inc0_ticks", 64'(bcnt), 64'd0);
        check("inc0_phase", 64'(b_phase), 64'h0);
        check("wrap_phase_a", 64'(a_phase), 64'h0);

        repeat (100) step();
        a_inc_wr = 1'b1; a_sel = 1'b1; a_inc_data = 24'h800000;
        step();
        a_inc_wr = 1'b0;
        check("incwr_old_used", 64'(a_phase), 64'h019400_019400);
        step();
        check("inc_ch1_half", 64'(a_phase[47:24]), 64'h819400);
        check("inc_ch1_clk", 64'(a_clock[1]), 64'h1);
        check("inc_ch1_notick", 64'(a_tick[1]), 64'h0);
        step();
        check("inc_ch1_tick", 64'(a_tick[1]), 64'h1);
        step();
        check("inc_ch1_tick_w", 64'(a_tick[1]), 64'h0);
        step();
        check("inc_ch1_tick2", 64'(a_tick[1]), 64'h1);
        check("inc_ch0_same", 64'(a_phase[23:0]), 64'h01A400);

        a_en_wr = 1'b1; a_sel = 1'b0; a_en_data = 1'b0;
        step();
        a_en_wr = 1'b0;
        cnt = 0;
        repeat (50) begin
            step();
            cnt += int'(a_tick[0]);
        end
        check("dis_frozen", 64'(a_phase[23:0]), 64'h01A800);
        check("dis_notick", 64'(cnt), 64'd0);
        a_en_wr = 1'b1; a_en_data = 1'b1;
        step();
        a_en_wr = 1'b0;
        check("reen_edge", 64'(a_phase[23:0]), 64'h01A800);
        step();
        check("reen_resume", 64'(a_phase[23:0]), 64'h01AC00);

        a_sync = 1'b1; a_inc_wr = 1'b1; a_sel = 1'b1; a_inc_data = 24'h000400;
        step();
        a_sync = 1'b0; a_inc_wr = 1'b0;
        check("sync_phase", 64'(a_phase), 64'h0);
        check("sync_tick", 64'(a_tick), 64'h0);
        t0 = 0; t1 = 0;
        for (int n = 1; n <= 16384; n++) begin
            step();
            if (a_tick[0] && t0 == 0) t0 = n;
            if (a_tick[1] && t1 == 0) t1 = n;
        end
        check("sync_t0", 64'(t0), 64'd16384);
        check("sync_t1", 64'(t1), 64'd16384);

        b_inc_wr = 1'b1; b_sel = 2'd0; b_inc_data = 8'd3;
        step();
        b_inc_wr = 1'b0;
        check("b_incwr_old", 64'(b_phase), 64'h0);
        cnt = 0; last = 0; mn = 1000; mx = 0; win = 0;
        for (int n = 1; n <= 768; n++) begin
            step();
            if (b_tick[0]) begin
                cnt++;
                if (n <= 256) win++;
                if (last != 0) begin
                    if (n - last < mn) mn = n - last;
                    if (n - last > mx) mx = n - last;
                end
                last = n;
            end
        end
        check("frac_total", 64'(cnt), 64'd9);
        check("frac_window", 64'(win), 64'd3);
        check("frac_min", 64'(mn), 64'd85);
        check("frac_max", 64'(mx), 64'd86);
        check("frac_phase", 64'(b_phase), 64'h0);

        b_en_wr = 1'b1; b_inc_wr = 1'b1; b_sel = 2'd3; b_en_data = 1'b0; b_inc_data = 8'h55;
        step();
        b_en_wr = 1'b0; b_inc_wr = 1'b0;
        step();
        check("badsel_ignored", 64'(b_phase), 64'h000006);

        b_en_wr = 1'b1; b_sel = 2'd2; b_en_data = 1'b0;
        step();
        b_inc_wr = 1'b1; b_en_data = 1'b1; b_inc_data = 8'd5;
        step();
        b_en_wr = 1'b0; b_inc_wr = 1'b0;
        step();
        check("both_wr_1", 64'(b_phase), 64'h05000F);
        step();
        check("both_wr_2", 64'(b_phase), 64'h0A0012);

        repeat (78) step();
        check("pre_wrap", 64'(b_phase[7:0]), 64'd252);
        b_en_wr = 1'b1; b_sel = 2'd0; b_en_data = 1'b0;
        cnt = 0;
        step();
        b_en_wr = 1'b0;
        cnt += int'(b_tick[0]);
        repeat (10) begin
            step();
            cnt += int'(b_tick[0]);
        end
        check("wrap_frozen", 64'(b_phase[7:0]), 64'd255);
        b_en_wr = 1'b1; b_en_data = 1'b1;
        step();
        b_en_wr = 1'b0;
        cnt += int'(b_tick[0]);
        step();
        check("wrap_resume", 64'(b_phase[7:0]), 64'd2);
        cnt += int'(b_tick[0]);
        repeat (5) begin
            step();
            cnt += int'(b_tick[0]);
        end
        check("wrap_one_tick", 64'(cnt), 64'd1);

        rst = 1'b1; a_inc_wr = 1'b1; a_sel = 1'b0; a_inc_data = 24'h123456;
        step();
        rst = 1'b0; a_inc_wr = 1'b0;
        check("rstwr_phase", 64'(a_phase), 64'h0);
        step();
        check("rstwr_def", 64'(a_phase), 64'h000400_000400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
